imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Instruction fetch sequencer for the 16-bit pipelined MIPS core. It owns the fetch PC and drives the address of the combinational, word-addressed InstructionMem. Each fetched word is buffered, together with its PC, in a DEPTH-entry prefetch queue that feeds decode through a valid/ready handshake. It also handles branch/jump redirects (queue flush) and stops fetching when it sees a halt word.

Parameters:
DEPTH, 4, prefetch queue entries (power of 2, >=2)
ADDR_W, 16, instruction memory address width (word address)
DATA_W, 16, instruction width
RESET_PC, 16'h0000, fetch PC value after reset
HALT_WORD, 16'hFFFF, instruction word that stops fetching

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Enable  in  1  fetch permitted while high
ImemAddress  out  ADDR_W  address to InstructionMem, equals FetchPC
ImemContent  in  DATA_W  InstructionMem combinational read data for ImemAddress
InstrValid  out  1  queue head holds a valid instruction
InstrReady  in  1  decode accepts the head this cycle
Instr  out  DATA_W  queue head instruction
InstrPC  out  ADDR_W  PC of queue head
Redirect  in  1  branch/jump taken; flush and refetch
RedirectPC  in  ADDR_W  new fetch PC when Redirect=1
Halted  out  1  FSM is in HALT
Count  out  clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (Reset_n=0, asynchronous): FetchPC=RESET_PC; queue empty (Count=0); state=IDLE; InstrValid=0; Instr=0; InstrPC=0; Halted=0.
- ImemAddress = FetchPC (registered, glitch-free). No other outputs are driven combinationally from ImemContent.
- FSM states:
  - IDLE -> RUN when Enable=1.
  - RUN -> IDLE when Enable=0.
  - RUN -> HALT when a pushed word equals HALT_WORD.
  - HALT -> RUN on Redirect when Enable=1, or -> IDLE on Redirect when Enable=0.
  - Enable has no effect in HALT.
- pop = InstrValid & InstrReady.
- push = (state==RUN) & ~Redirect & (Count<DEPTH | pop).
- On push:
  - {ImemContent, FetchPC} is written at the tail.
  - FetchPC <= FetchPC+1, wrapping 16'hFFFF -> 16'h0000.
  - Throughput is 1 word/cycle.
- Halt word: the halt word itself is pushed and delivered to decode. FetchPC still increments on that push. No further pushes occur until the FSM leaves HALT.
- Pop: the head advances and the read pointer wraps modulo DEPTH.
- Push and pop in the same cycle: Count is unchanged. This is legal when full (Count==DEPTH with pop).
- Full, no pop: no push, FetchPC holds, ImemAddress holds.
- Empty: InstrValid=0, Instr=0, InstrPC=0. A pop is impossible.
- Latency: a word at address A appears on Instr in the cycle after the edge where A was pushed, i.e. one clock from fetch to InstrValid.
- Redirect (highest priority, any state):
  - Count <= 0 and pointers reset.
  - A simultaneous pop is discarded; decode must not consume it.
  - FetchPC <= RedirectPC; no push that cycle.
  - The first push from RedirectPC happens on the next edge, if the state is RUN.
- Enable falling in RUN: the queue contents are retained and decode may drain them. Fetching resumes from the held FetchPC when Enable rises.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- Count never exceeds DEPTH, and no entry is overwritten before it is popped.

Test Plan:
- Reset then Enable=1, InstrReady=1, memory words 0x1000+addr -> ImemAddress 0,1,2,... per cycle; Instr 0x1000,0x1001,... with InstrPC 0,1,2, one per cycle from the cycle after the first push.
- InstrReady=0 for 8 cycles -> Count saturates at 4, ImemAddress holds at 4, entries PC 0..3 intact. Then InstrReady=1 -> PCs 0..7 delivered in order, none lost or duplicated.
- Redirect=1, RedirectPC=0x0013 while Count=3 and InstrReady=1 -> next cycle Count=0, InstrValid=0; following cycle Instr=mem[0x13], InstrPC=0x0013.
- mem[5]=0xFFFF -> words at 0..5 delivered, Halted=1, ImemAddress stays 6, Count reaches 0. Then Redirect to 0x0002 -> fetch restarts at 2.
- RESET_PC=16'hFFFE -> InstrPC sequence FFFE, FFFF, 0000, 0001.
- Reset_n pulsed low between clock edges while Count=2 -> outputs return to reset values at once. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_if.sv
// Fetch-side bus: instruction memory address/data, decode handshake and redirect.
interface imem_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] imem_address;
  logic [DATA_W-1:0] imem_content;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_address,
    input  imem_content,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  imem_address,
    output imem_content,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, buffers {word, PC} in a
// prefetch queue toward decode, and handles redirects and halt words.
module imem_fetch_ctrl #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  imem_fetch_if.master             bus,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];

  logic valid, pop, push, hit_halt;

  assign valid    = (cnt != '0);
  assign pop      = valid & bus.instr_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push     = (state_q == S_RUN) & ~bus.redirect & ((cnt < CNT_MAX) | pop);
  assign hit_halt = push & (bus.imem_content == HALT_WORD);

  // Queue control and fetch PC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        fetch_pc <= fetch_pc + PC_ONE;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Queue storage; contents are masked by valid so they need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= bus.imem_content;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // A pushed halt word wins over Enable falling in the same cycle, so a
  // later resume never fetches past the halt.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN: begin
        if (hit_halt)     state_d = S_HALT;
        else if (!enable) state_d = S_IDLE;
      end
      S_HALT: if (bus.redirect) state_d = enable ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_address = fetch_pc;
  assign bus.instr_valid  = valid;
  assign bus.instr        = valid ? q_instr[rd_ptr] : '0;
  assign bus.instr_pc     = valid ? q_pc[rd_ptr]    : '0;
  assign halted           = (state_q == S_HALT);
  assign count            = cnt;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: queue-based reference model driven by directed
// and random stimulus, plus a second instance exercising PC wrap-around.
module tb_imem_fetch_ctrl;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          enable2 = 1'b0;
  logic          halted, halted2;
  logic [CW-1:0] count, count2;

  imem_fetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  imem_fetch_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

  imem_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(16),
                    .RESET_PC(16'h0000), .HALT_WORD(16'hFFFF)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus),
    .halted(halted), .count(count));

  imem_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(16),
                    .RESET_PC(16'hFFFE), .HALT_WORD(16'hFFFF)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .bus(bus2),
    .halted(halted2), .count(count2));

  always #5 clk = ~clk;

  // Instruction memory: word = 0x1000 + address, optionally one halt word
  logic        halt_en = 1'b0;
  logic [15:0] halt_addr = 16'h0;
  always_comb bus.imem_content  = (halt_en && bus.imem_address == halt_addr) ?
                                  16'hFFFF : 16'h1000 + bus.imem_address;
  always_comb bus2.imem_content = 16'h1000 + bus2.imem_address;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of {pc, instr}, fetch PC, run/halt flags
  logic [31:0] m_q[$];
  logic [15:0] m_pc;
  bit          m_run, m_halt;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (halt_en && a == halt_addr) ? 16'hFFFF : 16'h1000 + a;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc   = 16'h0000;
    m_run  = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic model_step();
    bit          do_pop, do_push;
    logic [15:0] w;
    w       = mem_word(m_pc);
    do_pop  = (m_q.size() > 0) && bus.instr_ready;
    do_push = m_run && !bus.redirect && ((m_q.size() < DEPTH) || do_pop);
    if (bus.redirect) begin
      m_q.delete();
      m_pc = bus.redirect_pc;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back({m_pc, w});
        m_pc = m_pc + 16'd1;
      end
    end
    if (m_halt) begin
      if (bus.redirect) begin
        m_halt = 1'b0;
        m_run  = enable;
      end
    end else if (m_run) begin
      if (do_push && w == 16'hFFFF) begin
        m_halt = 1'b1;
        m_run  = 1'b0;
      end else if (!enable) begin
        m_run = 1'b0;
      end
    end else if (enable) begin
      m_run = 1'b1;
    end
  endtask

  function automatic logic [52:0] exp_vec();
    logic [15:0] i, p;
    i = 16'h0;
    p = 16'h0;
    if (m_q.size() > 0) begin
      i = m_q[0][15:0];
      p = m_q[0][31:16];
    end
    return {m_q.size() > 0, i, p, m_pc, 3'(m_q.size()), m_halt};
  endfunction

  function automatic logic [52:0] obs_vec();
    return {bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_address, count, halted};
  endfunction

  // Inputs are set at the falling edge; the model advances with the DUT edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    model_reset();
    n_checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL reset_state got=%h want=%h", obs_vec(), exp_vec());
    else n_pass++;
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL idle_after_reset got=%h want=%h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_stream();
    enable = 1'b1;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL stream c%0d got=%h want=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1;
    bus.instr_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL stall c%0d got=%h want=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({count, bus.imem_address, bus.instr_pc} !== {3'd4, 16'd4, 16'd0})
      $display("FAIL full_hold got=%h/%h/%h want=4/0004/0000",
               count, bus.imem_address, bus.instr_pc);
    else n_pass++;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL drain c%0d got=%h want=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    enable = 1'b1;
    bus.instr_ready = 1'b0;
    for (int c = 0; c < 10 && m_q.size() < 3; c++) tick();
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0013;
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec() || count !== 3'd0 || bus.instr_valid !== 1'b0)
      $display("FAIL redirect_flush got=%h want=%h", obs_vec(), exp_vec());
    else n_pass++;
    bus.redirect = 1'b0;
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.instr_pc !== 16'h0013 || bus.instr !== 16'h1013)
      $display("FAIL redirect_first got=%h want=%h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    halt_en   = 1'b1;
    halt_addr = 16'h0005;
    enable    = 1'b1;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL halt_run c%0d got=%h want=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({halted, bus.imem_address, count} !== {1'b1, 16'd6, 3'd0})
      $display("FAIL halt_state got=%h/%h/%h want=1/0006/0",
               halted, bus.imem_address, count);
    else n_pass++;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0002;
    tick();
    bus.redirect = 1'b0;
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.instr_pc !== 16'h0002 || halted !== 1'b0)
      $display("FAIL halt_restart got=%h want=%h", obs_vec(), exp_vec());
    else n_pass++;
    halt_en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    halt_en   = 1'b1;
    halt_addr = 16'h0030;
    for (int c = 0; c < 400; c++) begin
      enable          = ($urandom % 8) != 0;
      bus.instr_ready = ($urandom % 3) != 0;
      bus.redirect    = ($urandom % 16) == 0;
      bus.redirect_pc = 16'($urandom % 64);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random c%0d got=%h want=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    bus.redirect = 1'b0;
    halt_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    bus.instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    n_checks++;
    if (count !== 3'd2)
      $display("FAIL pre_reset_count got=%0d want=2", count);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL async_reset got=%h want=%h", obs_vec(), exp_vec());
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL after_reset c%0d got=%h want=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] pcs[$];
    logic [15:0] want[4];
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    enable = 1'b0;
    do_reset();
    enable2          = 1'b1;
    bus2.instr_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus2.instr_valid) pcs.push_back(bus2.instr_pc);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= pcs.size())
        $display("FAIL wrap_pc%0d got=none want=%h", k, want[k]);
      else if (pcs[k] !== want[k])
        $display("FAIL wrap_pc%0d got=%h want=%h", k, pcs[k], want[k]);
      else n_pass++;
    end
    n_checks++;
    if ({halted2, count2} !== {1'b0, 3'd1})
      $display("FAIL wrap_steady got=%h/%0d want=0/1", halted2, count2);
    else n_pass++;
    enable2 = 1'b0;
  endtask

  initial begin
    bus.instr_ready  = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 16'h0;
    bus2.instr_ready = 1'b0;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 16'h0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
